pingpong_bram: RTL and testbench

PINGPONG_BRAM -- requirements
Module: pingpong_bram

---
 rtl/pingpong_bram.sv | 141 ++++++++++++++
 tb/tb_pingpong_bram.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_bram.sv
// Double-buffered block RAM: one bank takes writes while the other serves reads; swap exchanges them.
// Optional macro BRAM_OUT_REG_EN adds an output register after the RAM read (read latency 2 instead of 1).
`timescale 1ns/1ps
module pingpong_bram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_ADDR_W  = 20,
    parameter int BYTE_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 re,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    input  logic                 swap,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic                 wr_bank,
    output logic [ADDR_W:0]      wr_count,
    output logic                 wr_full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]    mem_q [0:2*DEPTH-1];
    logic [DATA_W-1:0]    ram_rd_q;
    logic                 s1_vld_q;
    logic                 s1_err_q;
    logic [DATA_W-1:0]    data_out_q;
    logic                 rd_valid_q;
    logic                 rd_err_q;
    logic                 wr_bank_q;
    logic [ADDR_W:0]      wr_count_q;
    logic [ADDR_W:0]      wr_count_d;
    logic                 wr_full_q;

    logic [RD_ADDR_W-1:0] rd_idx_s;
    logic                 rd_oor_s;
    logic                 rd_bank_s;
    logic                 fin_vld_s;
    logic                 fin_err_s;
    logic [DATA_W-1:0]    fin_data_s;
    logic                 unused_s;

    assign rd_idx_s  = rd_addr >> BYTE_SHIFT;
    assign rd_oor_s  = |(rd_idx_s >> ADDR_W);
    assign rd_bank_s = ~wr_bank_q;
    assign unused_s  = ^rd_addr[BYTE_SHIFT-1:0];

    always_comb begin
        wr_count_d = wr_count_q;
        if (swap) begin
            wr_count_d = '0;
        end else if (we && (wr_count_q != DEPTH_C)) begin
            wr_count_d = wr_count_q + (ADDR_W+1)'(1);
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // RAM array is never reset; the read captures the bank chosen at the request edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{wr_bank_q, wr_addr}] <= data_in;
        end
        if (re) begin
            ram_rd_q <= mem_q[{rd_bank_s, rd_idx_s[ADDR_W-1:0]}];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            wr_count_q <= '0;
            wr_full_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_q ^ swap;
            wr_count_q <= wr_count_d;
            wr_full_q  <= (wr_count_d == DEPTH_C);
            s1_vld_q   <= re;
            s1_err_q   <= re & rd_oor_s;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic              s2_vld_q;
    logic              s2_err_q;
    logic [DATA_W-1:0] s2_data_q;

    // Extra pipeline stage between the RAM and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld_q  <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_err_q <= s1_err_q;
            if (s1_vld_q) begin
                s2_data_q <= ram_rd_q;
            end
        end
    end

    assign fin_vld_s  = s2_vld_q;
    assign fin_err_s  = s2_err_q;
    assign fin_data_s = s2_data_q;
`else
    assign fin_vld_s  = s1_vld_q;
    assign fin_err_s  = s1_err_q;
    assign fin_data_s = ram_rd_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= fin_vld_s;
            rd_err_q   <= fin_err_s;
            if (fin_vld_s) begin
                data_out_q <= fin_err_s ? '0 : fin_data_s;
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_bank  = wr_bank_q;
    assign wr_count = wr_count_q;
    assign wr_full  = wr_full_q;

endmodule

// File: tb/tb_pingpong_bram.sv
// Directed self-checking bench for pingpong_bram (default parameters, either configuration).
`timescale 1ns/1ps
module tb_pingpong_bram;

`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [7:0]  wr_addr;
    logic [31:0] data_in;
    logic        re;
    logic [19:0] rd_addr;
    logic        swap;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        rd_err;
    logic        wr_bank;
    logic [8:0]  wr_count;
    logic        wr_full;

    int n_chk = 0;
    int n_err = 0;

    pingpong_bram dut (
        .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .data_in(data_in),
        .re(re), .rd_addr(rd_addr), .swap(swap), .data_out(data_out),
        .rd_valid(rd_valid), .rd_err(rd_err), .wr_bank(wr_bank),
        .wr_count(wr_count), .wr_full(wr_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"},  data_out, 32'h0);
        chk({tag, "_vld"},   {31'd0, rd_valid}, 32'd0);
        chk({tag, "_err"},   {31'd0, rd_err}, 32'd0);
        chk({tag, "_bank"},  {31'd0, wr_bank}, 32'd0);
        chk({tag, "_cnt"},   {23'd0, wr_count}, 32'd0);
        chk({tag, "_full"},  {31'd0, wr_full}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wr_addr = 8'd0; data_in = 32'd0;
        re = 1'b0; rd_addr = 20'd0; swap = 1'b0;
        #1;
        chk_zero("rst");
        step(); step();
        reset = 1'b0;

        // Fill bank 0 with A0..A3
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wr_addr = 8'(i); data_in = 32'hA0 + 32'(i);
            step();
        end
        we = 1'b0;
        chk("cnt4",   {23'd0, wr_count}, 32'd4);
        chk("bank0",  {31'd0, wr_bank}, 32'd0);
        chk("full0",  {31'd0, wr_full}, 32'd0);

        swap = 1'b1; step(); swap = 1'b0;
        chk("swap_bank", {31'd0, wr_bank}, 32'd1);
        chk("swap_cnt",  {23'd0, wr_count}, 32'd0);

        re = 1'b1; rd_addr = 20'h0C; step(); re = 1'b0;
        chk("lat_early_vld", {31'd0, rd_valid}, 32'd0);
        repeat (LAT) step();
        chk("rd_a3",     data_out, 32'hA3);
        chk("rd_a3_vld", {31'd0, rd_valid}, 32'd1);
        chk("rd_a3_err", {31'd0, rd_err}, 32'd0);
        step();
        chk("rd_idle_vld",  {31'd0, rd_valid}, 32'd0);
        chk("rd_idle_hold", data_out, 32'hA3);

        // Saturation in bank 1: 259 writes
        for (int i = 0; i < 259; i++) begin
            we = 1'b1; wr_addr = 8'(i); data_in = 32'hC000_0000 + 32'(i);
            step();
            if (i == 254) begin
                chk("cnt255",  {23'd0, wr_count}, 32'd255);
                chk("full255", {31'd0, wr_full}, 32'd0);
            end
        end
        we = 1'b0;
        chk("cnt_sat",  {23'd0, wr_count}, 32'd256);
        chk("full_sat", {31'd0, wr_full}, 32'd1);

        // we + re + swap together: write goes to bank 1, read from bank 0
        we = 1'b1; wr_addr = 8'd5; data_in = 32'hDEAD_BEEF;
        re = 1'b1; rd_addr = 20'h04; swap = 1'b1;
        step();
        we = 1'b0; re = 1'b0; swap = 1'b0;
        chk("trip_cnt",  {23'd0, wr_count}, 32'd0);
        chk("trip_bank", {31'd0, wr_bank}, 32'd0);
        chk("trip_full", {31'd0, wr_full}, 32'd0);
        repeat (LAT) step();
        chk("trip_rd",     data_out, 32'hA1);
        chk("trip_rd_vld", {31'd0, rd_valid}, 32'd1);

        // Back-to-back reads of bank 1, with a concurrent write to bank 0
        re = 1'b1; rd_addr = 20'h14; we = 1'b1; wr_addr = 8'd7; data_in = 32'h77;
        step();
        we = 1'b0; rd_addr = 20'h00;
        step();
        re = 1'b0;
        repeat (LAT - 1) step();
        chk("b2b_0",     data_out, 32'hDEAD_BEEF);
        chk("b2b_0_vld", {31'd0, rd_valid}, 32'd1);
        step();
        chk("b2b_1",     data_out, 32'hC000_0100);
        chk("b2b_1_vld", {31'd0, rd_valid}, 32'd1);
        step();
        chk("b2b_end_vld", {31'd0, rd_valid}, 32'd0);
        chk("wr_cnt_rw",   {23'd0, wr_count}, 32'd1);

        // Out-of-range read then last in-range word
        re = 1'b1; rd_addr = 20'h400; step(); re = 1'b0;
        repeat (LAT) step();
        chk("oor_dout", data_out, 32'h0);
        chk("oor_vld",  {31'd0, rd_valid}, 32'd1);
        chk("oor_err",  {31'd0, rd_err}, 32'd1);
        step();
        chk("oor_err_clr", {31'd0, rd_err}, 32'd0);
        re = 1'b1; rd_addr = 20'h3FC; step(); re = 1'b0;
        repeat (LAT) step();
        chk("last_word",     data_out, 32'hC000_00FF);
        chk("last_word_err", {31'd0, rd_err}, 32'd0);

        // Reset during an in-flight read
        swap = 1'b1; step(); swap = 1'b0;
        chk("pre_rst_bank", {31'd0, wr_bank}, 32'd1);
        re = 1'b1; rd_addr = 20'h00; step(); re = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        step(); step();
        chk_zero("rst_hold");
        reset = 1'b0;
        we = 1'b1; wr_addr = 8'd0; data_in = 32'h55;
        step();
        we = 1'b0;
        chk("post_rst_vld0", {31'd0, rd_valid}, 32'd0);
        chk("post_rst_cnt",  {23'd0, wr_count}, 32'd1);
        repeat (LAT) begin
            step();
            chk("post_rst_vld", {31'd0, rd_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
